// File: rtl/wave_lut_gen.sv
// wave_lut_gen: mode-selectable waveform lookup stage between the phase counter and the DAC
// output register. Converts a phase address into an unsigned, offset-binary sample through a
// 2-stage pipeline. The shape and the square duty are only re-latched at a period wrap, so a
// shape switch never lands in the middle of a period.
//
// Optional feature macro: WAVE_INVERT_EN. When it is defined, an extra input `inv` is latched at
// wrap together with mode, and the sample is then mirrored as (2**DATA_W-1) - sample.
//
// Ports:
//   clk          rising-edge clock
//   en           asynchronous active-low reset
//   in_valid     addr/mode/duty are valid this cycle
//   addr         phase address (ADDR_W)
//   mode         requested shape: 0 sine, 1 triangle, 2 sawtooth, 3 square
//   duty         requested square high length, in address steps (ADDR_W)
//   inv          (WAVE_INVERT_EN only) requested output inversion
//   out_valid    q carries a new sample (in_valid delayed by 2 cycles)
//   q            sample (DATA_W); holds its value while out_valid is low
//   mode_active  shape currently applied
module wave_lut_gen #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] duty,
`ifdef WAVE_INVERT_EN
  input  logic              inv,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] q,
  output logic [1:0]        mode_active
);

  localparam int QD = 2 ** (ADDR_W - 2);
  localparam int KW = ADDR_W - 2;

  localparam logic [1:0] ModeSine   = 2'd0;
  localparam logic [1:0] ModeTri    = 2'd1;
  localparam logic [1:0] ModeSaw    = 2'd2;
  localparam logic [1:0] ModeSquare = 2'd3;

  localparam logic [DATA_W-1:0] Mid     = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0] DutyRst = {1'b1, {(ADDR_W-1){1'b0}}};
  localparam real               Pi      = 3.14159265358979323846;

  // Quarter-wave magnitude, rounded to nearest; entry QD is the positive peak.
  function automatic logic [DATA_W-2:0] sine_entry(input int i);
    real v;
    v = real'((2 ** (DATA_W - 1)) - 1) * $sin(Pi / 2.0 * real'(i) / real'(QD));
    return (DATA_W-1)'($rtoi(v + 0.5));
  endfunction

  logic [DATA_W-2:0] sin_tab [QD+1];

  for (genvar i = 0; i <= QD; i++) begin : g_sin_tab
    assign sin_tab[i] = sine_entry(i);
  end

  // Period / wrap tracking
  logic              first_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic [1:0]        mode_active_q;
  logic [ADDR_W-1:0] duty_active_q;

  // Stage 1
  logic              s1_valid_q;
  logic [1:0]        s1_mode_q;
  logic [1:0]        s1_quad_q;
  logic [KW:0]       s1_idx_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [ADDR_W-1:0] s1_duty_q;

  // Stage 2
  logic              out_valid_q;
  logic [DATA_W-1:0] q_q;

`ifdef WAVE_INVERT_EN
  logic inv_active_q;
  logic s1_inv_q;
  logic eff_inv;
`endif

  logic              wrap;
  logic [1:0]        eff_mode;
  logic [ADDR_W-1:0] eff_duty;
  logic [1:0]        quad;
  logic [KW-1:0]     k;
  logic [KW:0]       fold_idx;
  logic [DATA_W-1:0] sample_d;
  logic [DATA_W-2:0] sin_mag;
  logic [ADDR_W-2:0] tri_t;

  // A wrap lets the new settings apply to the very sample that triggered it.
  always_comb begin
    wrap     = in_valid && (first_q || (addr < last_addr_q));
    eff_mode = wrap ? mode : mode_active_q;
    eff_duty = wrap ? duty : duty_active_q;
    quad     = addr[ADDR_W-1 -: 2];
    k        = addr[KW-1:0];
    // Odd quadrants run the quarter table backwards.
    fold_idx = quad[0] ? ((KW+1)'(QD) - {1'b0, k}) : {1'b0, k};
  end

`ifdef WAVE_INVERT_EN
  assign eff_inv = wrap ? inv : inv_active_q;
`endif

  always_comb begin
    sample_d = '0;
    sin_mag  = sin_tab[s1_idx_q];
    tri_t    = s1_addr_q[ADDR_W-1] ? ~s1_addr_q[ADDR_W-2:0] : s1_addr_q[ADDR_W-2:0];
    case (s1_mode_q)
      ModeSine:   sample_d = s1_quad_q[1] ? (Mid - {1'b0, sin_mag}) : (Mid + {1'b0, sin_mag});
      ModeTri:    sample_d = DATA_W'(tri_t) << (DATA_W - ADDR_W + 1);
      ModeSaw:    sample_d = DATA_W'(s1_addr_q) << (DATA_W - ADDR_W);
      ModeSquare: sample_d = (s1_addr_q < s1_duty_q) ? '1 : '0;
      default:    sample_d = '0;
    endcase
`ifdef WAVE_INVERT_EN
    // All-ones minus x is a bitwise complement.
    if (s1_inv_q) sample_d = ~sample_d;
`endif
  end

  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      first_q       <= 1'b1;
      last_addr_q   <= '0;
      mode_active_q <= '0;
      duty_active_q <= DutyRst;
      s1_valid_q    <= 1'b0;
      s1_mode_q     <= '0;
      s1_quad_q     <= '0;
      s1_idx_q      <= '0;
      s1_addr_q     <= '0;
      s1_duty_q     <= '0;
      out_valid_q   <= 1'b0;
      q_q           <= '0;
`ifdef WAVE_INVERT_EN
      inv_active_q  <= 1'b0;
      s1_inv_q      <= 1'b0;
`endif
    end else begin
      if (in_valid) begin
        first_q     <= 1'b0;
        last_addr_q <= addr;
      end
      if (wrap) begin
        mode_active_q <= mode;
        duty_active_q <= duty;
`ifdef WAVE_INVERT_EN
        inv_active_q  <= inv;
`endif
      end
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= eff_mode;
        s1_quad_q <= quad;
        s1_idx_q  <= fold_idx;
        s1_addr_q <= addr;
        s1_duty_q <= eff_duty;
`ifdef WAVE_INVERT_EN
        s1_inv_q  <= eff_inv;
`endif
      end
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) q_q <= sample_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign q           = q_q;
  assign mode_active = mode_active_q;

endmodule

// File: tb/tb_wave_lut_gen.sv
// Self-checking bench for wave_lut_gen (ADDR_W=8, DATA_W=10). Inputs are driven and outputs
// sampled on the falling edge; a queue-free two-slot model delays the expected samples, which
// are computed straight from the waveform definitions with real arithmetic.
module tb_wave_lut_gen;

  localparam int AW = 8;
  localparam int DW = 10;
  localparam int FullScale = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] duty = '0;
  logic          inv = 1'b0;
  logic          out_valid;
  logic [DW-1:0] q;
  logic [1:0]    mode_active;

  wave_lut_gen #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk        (clk),
    .en         (en),
    .in_valid   (in_valid),
    .addr       (addr),
    .mode       (mode),
    .duty       (duty),
`ifdef WAVE_INVERT_EN
    .inv        (inv),
`endif
    .out_valid  (out_valid),
    .q          (q),
    .mode_active(mode_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit m_first;
  int m_last, m_mode, m_duty, m_inv;
  int pv[2];
  int pq[2];
  int exp_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_sample(input int m, input int a, input int d, input int iv);
    real s;
    int  r, v;
    case (m)
      0: begin
        s = 511.0 * $sin(2.0 * 3.14159265358979323846 * real'(a) / 256.0);
        r = $rtoi(((s < 0.0) ? -s : s) + 0.5);
        v = (s < 0.0) ? 512 - r : 512 + r;
      end
      1: v = ((a < 128) ? a : 255 - a) * 8;
      2: v = a * 4;
      default: v = (a < d) ? FullScale : 0;
    endcase
    return iv != 0 ? FullScale - v : v;
  endfunction

  task automatic model_reset();
    m_first = 1'b1;
    m_last  = 0;
    m_mode  = 0;
    m_duty  = 128;
    m_inv   = 0;
    pv[0] = 0; pv[1] = 0;
    pq[0] = 0; pq[1] = 0;
    exp_q = 0;
  endtask

  // One cycle: check what the DUT shows now, advance the model, drive the next input.
  task automatic step(input logic v, input logic [7:0] a, input logic [1:0] m,
                      input logic [7:0] d, input logic iv);
    int s;
    @(negedge clk);
    if (pv[1] != 0) exp_q = pq[1];
    check("out_valid", 32'(out_valid), 32'(pv[1]));
    check("q", 32'(q), 32'(exp_q));
    check("mode_active", 32'(mode_active), 32'(m_mode));
    s = 0;
    if (v) begin
      if (m_first || int'(a) < m_last) begin
        m_mode = int'(m);
        m_duty = int'(d);
`ifdef WAVE_INVERT_EN
        m_inv  = int'(iv);
`endif
      end
      m_first = 1'b0;
      m_last  = int'(a);
      s = ref_sample(m_mode, int'(a), m_duty, m_inv);
    end
    pv[1] = pv[0]; pq[1] = pq[0];
    pv[0] = int'(v); pq[0] = s;
    in_valid = v;
    addr     = a;
    mode     = m;
    duty     = d;
    inv      = iv;
  endtask

  task automatic flush();
    step(1'b0, 8'd0, 2'd0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 2'd0, 8'd0, 1'b0);
  endtask

  initial begin
    int cur;
    logic v;

    // Reset state
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mode_active", 32'(mode_active), 32'd0);
    en = 1'b1;

    // Sine quadrant points: 512, 1023, 512, 1
    step(1'b1, 8'd0,   2'd0, 8'd0, 1'b0);
    step(1'b1, 8'd64,  2'd0, 8'd0, 1'b0);
    step(1'b1, 8'd128, 2'd0, 8'd0, 1'b0);
    step(1'b1, 8'd192, 2'd0, 8'd0, 1'b0);
    flush();
    check("sine_192", 32'(q), 32'd1);

    // Triangle: 0, 1016, 1016, 0
    step(1'b1, 8'd0,   2'd1, 8'd0, 1'b0);
    step(1'b1, 8'd127, 2'd1, 8'd0, 1'b0);
    step(1'b1, 8'd128, 2'd1, 8'd0, 1'b0);
    step(1'b1, 8'd255, 2'd1, 8'd0, 1'b0);
    flush();

    // Sine sweep with a mid-period request for sawtooth that must wait for the wrap
    for (int a = 0; a < 256; a++) step(1'b1, 8'(a), (a >= 100) ? 2'd2 : 2'd0, 8'd0, 1'b0);
    step(1'b1, 8'd0,  2'd2, 8'd0, 1'b0);
    step(1'b1, 8'd10, 2'd2, 8'd0, 1'b0);
    flush();
    check("saw_10", 32'(q), 32'd40);

    // Square duty 64, then a period with duty 0
    step(1'b1, 8'd0,   2'd3, 8'd64, 1'b0);
    step(1'b1, 8'd63,  2'd3, 8'd0,  1'b0);
    step(1'b1, 8'd64,  2'd3, 8'd0,  1'b0);
    step(1'b1, 8'd255, 2'd3, 8'd0,  1'b0);
    for (int a = 0; a < 256; a += 15) step(1'b1, 8'(a), 2'd3, 8'd0, 1'b0);
    flush();

    // Full-scale duty: low only at the last address
    step(1'b1, 8'd0,   2'd3, 8'd255, 1'b0);
    step(1'b1, 8'd254, 2'd3, 8'd0,   1'b0);
    step(1'b1, 8'd255, 2'd3, 8'd0,   1'b0);
    flush();

    // Valid pattern 1,0,0,1 with q holding in the gap
    step(1'b1, 8'd20, 2'd1, 8'd0, 1'b0);
    step(1'b0, 8'd30, 2'd2, 8'd0, 1'b0);
    step(1'b0, 8'd40, 2'd2, 8'd0, 1'b0);
    step(1'b1, 8'd50, 2'd1, 8'd0, 1'b0);
    flush();

    // Randomised traffic
    cur = 0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) begin
        if ($urandom_range(0, 15) == 0) cur = int'($urandom_range(0, 255));
        else cur = (cur + int'($urandom_range(1, 40))) % 256;
      end
      step(v, 8'(cur), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));
    end
    flush();

    // Asynchronous reset mid-sweep
    for (int a = 0; a <= 50; a += 5) step(1'b1, 8'(a), 2'd1, 8'd0, 1'b0);
    #2;
    en = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_q", 32'(q), 32'd0);
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_mode_active", 32'(mode_active), 32'd0);
    model_reset();
    @(negedge clk);
    en = 1'b1;
    step(1'b1, 8'd200, 2'd2, 8'd0, 1'b0);
    step(1'b1, 8'd210, 2'd2, 8'd0, 1'b0);
    flush();
    check("post_rst_mode", 32'(mode_active), 32'd2);
    step(1'b0, 8'd0, 2'd0, 8'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_lut_gen.md
Name: wave_lut_gen

Overview:
- Parametrised, mode-selectable waveform lookup stage for the function generator; successor to the fixed 8-bit-address, 10-bit-output per-shape ROMs.
- Sits between the phase/address counter and the DAC output register; converts a phase address into an unsigned, offset-binary sample.
- Adds: a quarter-wave sine table, selectable shape, programmable square duty, a valid handshake, a 2-stage pipeline, and mode/duty changes that take effect only at period wrap (glitch-free switching).

Parameters:
- ADDR_W, 8, phase address width; must be at least 4.
- DATA_W, 10, sample width; must be at least ADDR_W.
- QD, 2**(ADDR_W-2), quarter-table depth, derived (localparam).

Ports:
- clk  in  1  rising-edge clock.
- en  in  1  asynchronous active-low reset.
- in_valid  in  1  addr/mode/duty are valid this cycle.
- addr  in  ADDR_W  phase address.
- mode  in  2  requested shape: 0 sine, 1 triangle, 2 sawtooth, 3 square.
- duty  in  ADDR_W  requested square high length, in address steps.
- out_valid  out  1  q carries a new sample.
- q  out  DATA_W  sample.
- mode_active  out  2  shape currently applied.

Behaviour:
- Reset (en low, asynchronous):
  - q=0, out_valid=0, mode_active=0.
  - Internal duty_active=2**(ADDR_W-1); last_addr=0; first flag=1.
  - Both pipeline stages are cleared.
- Wrap rule: an accepted sample (in_valid=1) is a wrap when first=1 or addr < last_addr.
  - On a wrap, mode_active<=mode and duty_active<=duty, and the new values apply to that same sample.
  - first clears on the first accepted sample.
  - last_addr updates on every accepted sample.
- Pipeline, 2-cycle latency:
  - Stage 1 registers the folded index, quadrant and effective mode.
  - Stage 2 performs the table lookup and arithmetic, then registers q.
  - out_valid mirrors in_valid delayed by 2 cycles.
  - When out_valid=0, q holds its last value.
  - Bubbles propagate unchanged; there is no back-pressure.
- Sine (mode 0):
  - Table Q[i]=round((2**(DATA_W-1)-1)*sin(pi/2*i/QD)) for i=0..QD (QD+1 entries), built by constant function/initial block.
  - mid=2**(DATA_W-1); quadrant = addr top 2 bits; k = low ADDR_W-2 bits.
  - quadrant 0: mid+Q[k]; quadrant 1: mid+Q[QD-k]; quadrant 2: mid-Q[k]; quadrant 3: mid-Q[QD-k].
  - Output range is 1..2**DATA_W-1; no overflow.
- Triangle (mode 1):
  - t = addr MSB ? ~addr[ADDR_W-2:0] : addr[ADDR_W-2:0].
  - q = t left-justified, zero-filled LSBs.
- Sawtooth (mode 2): q = addr left-justified, zero-filled LSBs.
- Square (mode 3):
  - q = all-ones when addr < duty_active, else 0.
  - duty=0 gives constant 0; duty=2**ADDR_W-1 gives low only at the last address.
- mode/duty changes without a wrap are ignored; mode_active does not change.
- Reset mid-operation discards in-flight samples; the first sample after release is a wrap.

Optional Feature:
- Macro: WAVE_INVERT_EN.
- When defined:
  - Extra input port inv (1 bit) exists.
  - inv is latched alongside mode at wrap; reset value 0.
  - When the latched inv=1, q = (2**DATA_W-1) - sample, applied in stage 2 with no added latency.
- When undefined: the port is absent and output is never inverted.

Test Plan:
All scenarios use ADDR_W=8, DATA_W=10.
- Reset, mode=0, feed addr 0, 64, 128, 192 back-to-back -> q = 512, 1023, 512, 1, each 2 cycles after input; out_valid high for 4 cycles.
- mode=1, addr 0, 127, 128, 255 -> q = 0, 1016, 1016, 0.
- Sweep 0..255 in mode 0; set mode=2 at addr 100 -> samples stay sine through 255, mode_active stays 0; next addr 0 gives mode_active=2; addr 10 -> q = 40.
- mode=3, duty=64 at wrap, addr 63, 64 -> q = 1023, 0; next period with duty=0 -> q = 0 for all addresses.
- in_valid pattern 1,0,0,1 -> out_valid 1,0,0,1 delayed by 2 cycles; q unchanged during the gap.
- Pull en low mid-sweep -> q=0, out_valid=0 immediately (asynchronously); after release, first accepted addr=200 latches the current mode with no wrap required.
